// File: rtl/exec_unit.sv
// exec_unit: accumulator execute stage driven by fetch/decode/execute strobes
module exec_unit #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch,
  input  logic              decode,
  input  logic              execute,
  input  logic [ADDR_W-1:0] pc_adr,
  input  logic [DATA_W-1:0] mem_data_in,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_nxt,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              zero,
  output logic              halt
);
  typedef enum logic [2:0] {OP_NOP, OP_LD, OP_ADD, OP_SUB, OP_STR, OP_AND, OP_JMP, OP_HLT} op_t;
  logic [DATA_W-1:0] ir;
  logic              ir_valid;
  op_t               op;
  logic              do_dec;
  logic              do_exe;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic [DATA_W-1:0] acc_nxt;
  logic              carry_nxt;
  logic              upd_z;
  assign op = op_t'(ir[DATA_W-1:DATA_W-3]);
  // fetch outranks decode outranks execute; execute also needs a pending instruction
  assign do_dec = decode && !fetch && !halt;
  // reset gates the strobes directly so a reset mid-execute kills mem_we/pc_load at once
  assign do_exe = execute && !fetch && !decode && ir_valid && !halt && reset;
  assign mem_adr = fetch ? pc_adr : decode ? mem_data_in[ADDR_W-1:0] : ir[ADDR_W-1:0];
  assign mem_wdata = acc;
  assign mem_we = do_exe && op == OP_STR;
  assign pc_load = do_exe && op == OP_JMP;
  assign pc_nxt = ir[ADDR_W-1:0];
  assign sum = {1'b0, acc} + {1'b0, mem_data_in};
  assign dif = {1'b0, acc} - {1'b0, mem_data_in};
  // result and flag selection for the instruction in ir; the MSB of dif is the borrow
  always_comb begin
    acc_nxt = op == OP_LD  ? mem_data_in :
              op == OP_ADD ? sum[DATA_W-1:0] :
              op == OP_SUB ? dif[DATA_W-1:0] :
              op == OP_AND ? (acc & mem_data_in) : acc;
    carry_nxt = op == OP_ADD ? sum[DATA_W] : op == OP_SUB ? dif[DATA_W] : carry;
    upd_z = op inside {OP_LD, OP_ADD, OP_SUB, OP_AND};
  end
  // instruction register, accumulator, flags and sticky halt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ir       <= '0;
      ir_valid <= 1'b0;
      acc      <= '0;
      carry    <= 1'b0;
      zero     <= 1'b1;
      halt     <= 1'b0;
    end else if (do_dec) begin
      ir       <= mem_data_in;
      ir_valid <= 1'b1;
    end else if (do_exe) begin
      acc      <= acc_nxt;
      carry    <= carry_nxt;
      ir_valid <= 1'b0;
      if (upd_z) zero <= acc_nxt == '0;
      if (op == OP_HLT) halt <= 1'b1;
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed and random checks of exec_unit against a behavioural model
module tb_exec_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       fetch = 1'b0, decode = 1'b0, execute = 1'b0;
  logic [4:0] pc_adr = '0;
  logic [7:0] mem_data_in = '0;
  logic [4:0] mem_adr, pc_nxt;
  logic [7:0] mem_wdata, acc;
  logic       mem_we, pc_load, carry, zero, halt;

  exec_unit #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .fetch(fetch), .decode(decode), .execute(execute),
    .pc_adr(pc_adr), .mem_data_in(mem_data_in), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .pc_load(pc_load), .pc_nxt(pc_nxt), .acc(acc), .carry(carry),
    .zero(zero), .halt(halt));

  always #5 clk = ~clk;

  logic [7:0] mem [32];
  int n_cmp = 0, n_fail = 0;
  int pc = 0;
  int macc, mc, mz, mh, mir, mirv;
  logic pl_seen;
  logic [4:0] nxt_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    macc = 0; mc = 0; mz = 1; mh = 0; mir = 0; mirv = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_acc"}, 32'(acc), 32'(macc));
    chk({tag, "_carry"}, 32'(carry), 32'(mc));
    chk({tag, "_zero"}, 32'(zero), 32'(mz));
    chk({tag, "_halt"}, 32'(halt), 32'(mh));
  endtask

  task automatic step(input logic f, input logic d, input logic e);
    int m, op, s, ea;
    logic dd, de, ewe, epl, we;
    logic [4:0] a;
    logic [7:0] wd, rd;
    @(negedge clk);
    fetch = f; decode = d; execute = e; pc_adr = 5'(pc);
    #1;
    m = int'(mem_data_in);
    op = mir / 32;
    ea = f ? pc % 32 : d ? m % 32 : mir % 32;
    dd = !mh && !f && d;
    de = !mh && !f && !d && e && mirv == 1;
    ewe = de && op == 4;
    epl = de && op == 6;
    chk("mem_adr", 32'(mem_adr), 32'(ea));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("pc_load", 32'(pc_load), 32'(epl));
    if (epl) chk("pc_nxt", 32'(pc_nxt), 32'(mir % 32));
    if (ewe) chk("mem_wdata", 32'(mem_wdata), 32'(macc));
    chk_state("st");
    pl_seen = pc_load; nxt_seen = pc_nxt;
    a = mem_adr; we = mem_we; wd = mem_wdata;
    if (dd) begin
      mir = m; mirv = 1;
    end else if (de) begin
      case (op)
        1: macc = m;
        2: begin s = macc + m; mc = s > 255 ? 1 : 0; macc = s % 256; end
        3: begin mc = m > macc ? 1 : 0; macc = (macc - m + 256) % 256; end
        5: macc = macc & m;
        7: mh = 1;
        default: ;
      endcase
      if (op == 1 || op == 2 || op == 3 || op == 5) mz = macc == 0 ? 1 : 0;
      mirv = 0;
    end
    @(posedge clk);
    #1;
    rd = mem[a];
    if (we) mem[a] = wd;
    mem_data_in = rd;
  endtask

  task automatic run_instr();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    pc = pl_seen ? int'(nxt_seen) : (pc + 1) % 32;
  endtask

  task automatic exec_op(input int op, input int addr, input int m);
    mem[addr] = 8'(m);
    mem[0] = 8'(op * 32 + addr);
    pc = 0;
    run_instr();
  endtask

  task automatic do_reset();
    @(negedge clk);
    fetch = 1'b0; decode = 1'b0; execute = 1'b0; reset = 1'b0;
    #1;
    model_reset();
    chk_state("rst");
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_pl", 32'(pc_load), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int saved;
    logic we2;
    foreach (mem[i]) mem[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_state("por");
    chk("por_adr", 32'(mem_adr), 32'd0);
    chk("por_we", 32'(mem_we), 32'd0);
    chk("por_pl", 32'(pc_load), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    chk("nodec_acc", 32'(acc), 32'd0);
    mem[0] = 8'h23; mem[1] = 8'h44; mem[2] = 8'h85; mem[3] = 8'd2; mem[4] = 8'd5; mem[5] = 8'd0;
    pc = 0;
    run_instr();
    chk("prog_ld", 32'(acc), 32'd2);
    run_instr();
    chk("prog_add", 32'(acc), 32'd7);
    run_instr();
    chk("prog_str", 32'(mem[5]), 32'd7);
    exec_op(1, 10, 8'hFF);
    exec_op(2, 10, 1);
    chk("add_acc", 32'(acc), 32'd0);
    chk("add_c", 32'(carry), 32'd1);
    chk("add_z", 32'(zero), 32'd1);
    exec_op(1, 11, 3);
    exec_op(3, 11, 5);
    chk("sub_acc", 32'(acc), 32'hFE);
    chk("sub_c", 32'(carry), 32'd1);
    chk("sub_z", 32'(zero), 32'd0);
    exec_op(1, 12, 0);
    chk("ld0_acc", 32'(acc), 32'd0);
    chk("ld0_z", 32'(zero), 32'd1);
    chk("ld0_c", 32'(carry), 32'd1);
    exec_op(1, 12, 8'h5A);
    exec_op(5, 12, 8'h0F);
    chk("and_acc", 32'(acc), 32'h0A);
    mem[0] = 8'hC7;
    pc = 0;
    run_instr();
    chk("jmp_pl", 32'(pl_seen), 32'd1);
    chk("jmp_nxt", 32'(nxt_seen), 32'd7);
    saved = int'(acc);
    exec_op(7, 13, 0);
    chk("hlt", 32'(halt), 32'd1);
    exec_op(2, 13, 9);
    chk("hlt_add", 32'(acc), 32'(saved));
    chk("hlt_sticky", 32'(halt), 32'd1);
    do_reset();
    step(1'b0, 1'b0, 1'b1);
    chk("nodec2_acc", 32'(acc), 32'd0);
    exec_op(1, 14, 9);
    mem[0] = 8'h90; mem[16] = 8'h33; pc = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    fetch = 1'b0; decode = 1'b0; execute = 1'b1;
    #1;
    chk("str_we_pre", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("str_we_rst", 32'(mem_we), 32'd0);
    chk("str_acc_rst", 32'(acc), 32'd0);
    chk("str_z_rst", 32'(zero), 32'd1);
    model_reset();
    we2 = mem_we;
    @(posedge clk);
    #1;
    if (we2) mem[mem_adr] = mem_wdata;
    @(negedge clk);
    execute = 1'b0; reset = 1'b1;
    #1;
    chk("str_mem", 32'(mem[16]), 32'h33);
    foreach (mem[i]) mem[i] = 8'($urandom);
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 40) == 0) do_reset();
      else begin
        pc = int'($urandom_range(0, 31));
        step(1'($urandom), 1'($urandom), 1'($urandom));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/exec_unit.md
EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 Parameter ADDR_W, default 5, memory address and PC width.
REQ-002 Parameter DATA_W, default 8, data, instruction and accumulator width; opcode = [DATA_W-1:DATA_W-3], operand address = [ADDR_W-1:0].
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 fetch  in  1  fetch-phase strobe from the fde sequencer.
REQ-006 decode  in  1  decode-phase strobe from fde.
REQ-007 execute  in  1  execute-phase strobe from fde.
REQ-008 pc_adr  in  ADDR_W  current PC address (pc crnt_adr).
REQ-009 mem_data_in  in  DATA_W  ram data_out; registered read, 1-cycle latency.
REQ-010 mem_adr  out  ADDR_W  ram address.
REQ-011 mem_wdata  out  DATA_W  ram data_in.
REQ-012 mem_we  out  1  ram write enable.
REQ-013 pc_load / pc_nxt  out  1 / ADDR_W  PC load request and target.
REQ-014 acc  out  DATA_W  accumulator; carry, zero  out  1  flags.
REQ-015 halt  out  1  sticky halt; gates fde enable externally.

Function
REQ-016 mem_adr SHALL be combinational: pc_adr when fetch=1, mem_data_in[ADDR_W-1:0] when decode=1, otherwise ir[ADDR_W-1:0].
REQ-017 Rising edge with decode=1 and halt=0 SHALL load ir <= mem_data_in and set ir_valid=1.
REQ-018 During the cycle with execute=1, ir_valid=1 and halt=0, mem_data_in is the operand M; the opcode takes effect at the end of that cycle, then ir_valid clears.
REQ-019 Opcodes: 000 NOP; 001 LD acc<=M; 010 ADD {carry,acc}<=acc+M; 011 SUB acc<=acc-M, carry=borrow (1 iff M>acc); 100 STR; 101 AND acc<=acc&M; 110 JMP; 111 HLT.
REQ-020 STR SHALL assert mem_we=1 combinationally for exactly the execute cycle with mem_wdata=acc; mem_we=0 in every other cycle.
REQ-021 JMP SHALL assert pc_load=1 for exactly the execute cycle with pc_nxt=ir[ADDR_W-1:0]; pc_load=0 otherwise.
REQ-022 HLT SHALL set halt=1 at the end of the execute cycle; halt remains 1 until reset.
REQ-023 zero SHALL update to (new acc==0) on LD/ADD/SUB/AND only; carry SHALL update on ADD/SUB only; LD/AND leave carry unchanged.
REQ-024 Arithmetic wraps modulo 2^DATA_W; ADD carry = bit DATA_W of the unsigned sum.
REQ-025 execute=1 with ir_valid=0 (no preceding decode) SHALL be ignored: no state change, mem_we=0, pc_load=0.
REQ-026 A second decode before execute SHALL overwrite ir (last decode wins).
REQ-027 Strobes asserted simultaneously: priority fetch > decode > execute for mem_adr; the lower-priority strobe is ignored that cycle.
REQ-028 While halt=1: ir, acc, flags frozen; mem_we=0, pc_load=0; mem_adr still follows REQ-016.

Reset
REQ-029 reset=0 SHALL asynchronously clear acc=0, carry=0, zero=1, halt=0, ir=0, ir_valid=0.
REQ-030 reset asserted mid-instruction SHALL abort it: mem_we and pc_load go 0 immediately, and no partial result is retained.
REQ-031 After reset release, the first effective instruction SHALL be the one whose decode strobe follows the release.

Verification
REQ-032 mem[0..5]={8'h23,8'h44,8'h85,2,5,0}, three F/D/E rounds -> acc=2, then 7, then mem[5]=7; mem_we high only in the third execute cycle.
REQ-033 acc=8'hFF, ADD M=1 -> acc=0, carry=1, zero=1.
REQ-034 acc=3, SUB M=5 -> acc=8'hFE, carry=1, zero=0; then LD M=0 -> acc=0, zero=1, carry still 1.
REQ-035 JMP 8'hC7 -> pc_load=1 and pc_nxt=7 for one cycle; then HLT -> halt=1, and a following ADD leaves acc unchanged.
REQ-036 execute strobe with no prior decode -> acc, flags and mem unchanged; reset=0 pulsed during the execute of STR -> mem_we drops the same instant, acc=0, zero=1.
